repeater_checker_mc: RTL
========================

# repeater_checker_mc

Multi-channel, parametrised passive scoreboard for link repeaters and inter-chip bridges. Each channel snoops a repeater's input handshake (val/rdy/dat) and output handshake, queues accepted input words in a per-channel FIFO, and compares every accepted output word against the oldest queued word. It reports sticky per-channel overflow, extra-data and mismatch flags, a saturating error count, and a first-error capture record. It drives nothing on the snooped buses and sits beside repeaters in simulation and FPGA debug builds.

## Interface

- DATA_WIDTH, 64: snooped word width.
- DEPTH, 64: per-channel scoreboard entries; power of two, ≥2.
- NUM_CHAN, 4: independent channels, 1..16.
- Derived: PTR_W = $clog2(DEPTH); CNT_W = PTR_W+1; CH_W = max(1, $clog2(NUM_CHAN)).

- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of sticky flags, error count and capture record; FIFOs untouched.
- in_val  in  NUM_CHAN  repeater input valid, per channel.
- in_rdy  in  NUM_CHAN  repeater input ready.
- in_dat  in  NUM_CHAN*DATA_WIDTH  repeater input data; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- out_val  in  NUM_CHAN  repeater output valid.
- out_rdy  in  NUM_CHAN  repeater output ready.
- out_dat  in  NUM_CHAN*DATA_WIDTH  repeater output data, same packing.
- overflow  out  NUM_CHAN  sticky: push while full.
- extradata  out  NUM_CHAN  sticky: pop with nothing to match.
- mismatch  out  NUM_CHAN  sticky: data compare failure.
- error  out  1  OR of all sticky flags.
- occupancy  out  NUM_CHAN*CNT_W  live per-channel entry count.
- err_valid  out  1  capture record holds an error.
- err_chan  out  CH_W  channel of first error.
- err_code  out  2  1 mismatch, 2 extradata, 3 overflow.
- err_exp  out  DATA_WIDTH  expected word (0 unless mismatch).
- err_got  out  DATA_WIDTH  word seen (output word, or dropped input word for overflow).
- err_cnt  out  16  total error events, saturates at 16'hFFFF.

## Operation

- push_c = in_val&in_rdy; pop_c = out_val&out_rdy, per channel.
- FIFO: wr/rd pointers PTR_W bits, wrap modulo DEPTH; occupancy counter CNT_W bits, 0..DEPTH.
- Push, not full: write at wr, wr+1. Push while full and no pop: word dropped, pointers unchanged, overflow event.
- Pop, occupancy>0: compare out_dat to mem[rd]; rd+1; unequal → mismatch event.
- Pop, empty, simultaneous push: bypass — compare out_dat to in_dat, nothing stored, occupancy stays 0.
- Pop, empty, no push: extradata event, no compare, pointers unchanged.
- Push+pop when full: legal, occupancy stays DEPTH, no overflow.
- Event sets channel sticky flag; err_cnt += number of events this cycle (all channels), saturating.
- Capture: if err_valid=0 and any event, record lowest-indexed channel with an event; within a channel priority mismatch > extradata > overflow. Held until clr/rst.
- clr and new event same cycle: clear then apply event (set wins); err_cnt becomes event count.

## Timing

- All outputs registered; flags, capture, err_cnt update the cycle after the handshake edge. occupancy reflects pushes/pops of previous cycle.
- Compare uses memory contents before this cycle's write; read is combinational from array, registered result.
- Reset: all outputs 0, pointers/occupancy 0; memory not reset. Reset mid-traffic discards queued words; first post-reset pop on empty channel is extradata.

## Structure

- Package repeater_checker_pkg: err_code constants (ERR_NONE=0, ERR_MISMATCH=1, ERR_EXTRA=2, ERR_OVERFLOW=3), capture record struct.
- Sub-module repeater_checker_chan: one channel FIFO, compare, event outputs (mismatch/extra/overflow pulses plus exp/got words); top generates NUM_CHAN instances and holds sticky flags, priority capture, counter.

## Test plan

- Ch0 push 0x11,0x22,0x33 then pop same order → occupancy 3→0, no flags, err_cnt 0.
- Ch1 pop 0xAA while empty, no push → extradata[1]=1, err_code 2, err_chan 1, err_got 0xAA, err_cnt 1.
- Ch2 push DEPTH words, then push 0xDEAD → overflow[2]=1, err_code 3, err_got 0xDEAD, occupancy DEPTH; next DEPTH pops match.
- Ch0 and ch3 mismatch same cycle (exp 0x5, got 0x6 on ch0) → err_chan 0, err_code 1, err_exp 0x5, err_got 0x6, err_cnt 2.
- Empty ch1 push 0x77 and pop 0x77 same cycle → no flags, occupancy 0; repeat with pop 0x78 → mismatch, err_exp 0x77.
- clr asserted with simultaneous ch0 extradata → only extradata[0]=1, err_cnt 1; assert rst mid-burst → all outputs 0 next cycle.

Source files
------------

// File: rtl/repeater_checker_pkg.sv
// Shared types for the repeater scoreboard: error codes, capture header
// and the per-channel event priority helper.
package repeater_checker_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_EXTRA    = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  typedef struct packed {
    logic      valid;
    err_code_e code;
  } err_hdr_t;

  // Within one channel a mismatch outranks extradata, which outranks overflow.
  function automatic err_code_e err_code_f(input logic mis, input logic ext, input logic ovf);
    err_code_e code_v;
    if (mis) begin
      code_v = ERR_MISMATCH;
    end else if (ext) begin
      code_v = ERR_EXTRA;
    end else if (ovf) begin
      code_v = ERR_OVERFLOW;
    end else begin
      code_v = ERR_NONE;
    end
    return code_v;
  endfunction

endpackage

// File: rtl/repeater_checker_chan.sv
// One scoreboard channel: FIFO of accepted input words, compare against
// accepted output words, single-cycle event pulses with the words involved.
module repeater_checker_chan
  import repeater_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  input  logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  out_val,
  input  logic                  out_rdy,
  input  logic [DATA_WIDTH-1:0] out_dat,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  ev_mismatch,
  output logic                  ev_extra,
  output logic                  ev_overflow,
  output logic [DATA_WIDTH-1:0] exp_word,
  output logic [DATA_WIDTH-1:0] got_word
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_r;
  logic [PTR_W-1:0]      rd_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  rd_adv_s;
  logic [CNT_W-1:0]      occ_nxt_s;

  assign push_s  = in_val & in_rdy;
  assign pop_s   = out_val & out_rdy;
  assign empty_s = (occupancy == {CNT_W{1'b0}});
  assign full_s  = (occupancy == CNT_W'(DEPTH));

  // Handshake decode: store/drop/compare decisions and event pulses.
  always_comb begin
    wr_en_s     = 1'b0;
    rd_adv_s    = 1'b0;
    occ_nxt_s   = occupancy;
    ev_mismatch = 1'b0;
    ev_extra    = 1'b0;
    ev_overflow = 1'b0;
    exp_word    = {DATA_WIDTH{1'b0}};
    got_word    = {DATA_WIDTH{1'b0}};
    if (pop_s) begin
      got_word = out_dat;
      if (!empty_s) begin
        // When full, wr == rd: the read sees the old word before this write lands.
        exp_word    = mem_r[rd_r];
        ev_mismatch = (mem_r[rd_r] != out_dat);
        rd_adv_s    = 1'b1;
        if (push_s) begin
          wr_en_s = 1'b1;
        end else begin
          occ_nxt_s = occupancy - CNT_W'(1);
        end
      end else if (push_s) begin
        // Empty bypass: the word passes straight through, nothing is stored.
        exp_word    = in_dat;
        ev_mismatch = (in_dat != out_dat);
      end else begin
        ev_extra = 1'b1;
      end
    end else if (push_s) begin
      if (!full_s) begin
        wr_en_s   = 1'b1;
        occ_nxt_s = occupancy + CNT_W'(1);
      end else begin
        ev_overflow = 1'b1;
        got_word    = in_dat;
      end
    end else begin
      occ_nxt_s = occupancy;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r      <= {PTR_W{1'b0}};
      rd_r      <= {PTR_W{1'b0}};
      occupancy <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_r <= wr_r + PTR_W'(1);
      end
      if (rd_adv_s) begin
        rd_r <= rd_r + PTR_W'(1);
      end
      occupancy <= occ_nxt_s;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_r] <= in_dat;
    end
  end

endmodule

// File: rtl/repeater_checker_mc.sv
// Multi-channel passive repeater scoreboard: per-channel FIFO compare,
// sticky flags, saturating error count and first-error capture.
module repeater_checker_mc
  import repeater_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int NUM_CHAN   = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1,
  localparam int CH_W      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic [NUM_CHAN-1:0]            in_val,
  input  logic [NUM_CHAN-1:0]            in_rdy,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] in_dat,
  input  logic [NUM_CHAN-1:0]            out_val,
  input  logic [NUM_CHAN-1:0]            out_rdy,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] out_dat,
  output logic [NUM_CHAN-1:0]            overflow,
  output logic [NUM_CHAN-1:0]            extradata,
  output logic [NUM_CHAN-1:0]            mismatch,
  output logic                           error,
  output logic [NUM_CHAN*CNT_W-1:0]      occupancy,
  output logic                           err_valid,
  output logic [CH_W-1:0]                err_chan,
  output logic [1:0]                     err_code,
  output logic [DATA_WIDTH-1:0]          err_exp,
  output logic [DATA_WIDTH-1:0]          err_got,
  output logic [15:0]                    err_cnt
);

  logic [NUM_CHAN-1:0]   ev_mis_s;
  logic [NUM_CHAN-1:0]   ev_ext_s;
  logic [NUM_CHAN-1:0]   ev_ovf_s;
  logic [DATA_WIDTH-1:0] exp_w_s [NUM_CHAN];
  logic [DATA_WIDTH-1:0] got_w_s [NUM_CHAN];

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    repeater_checker_chan #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .in_val     (in_val[c]),
      .in_rdy     (in_rdy[c]),
      .in_dat     (in_dat[c*DATA_WIDTH +: DATA_WIDTH]),
      .out_val    (out_val[c]),
      .out_rdy    (out_rdy[c]),
      .out_dat    (out_dat[c*DATA_WIDTH +: DATA_WIDTH]),
      .occupancy  (occupancy[c*CNT_W +: CNT_W]),
      .ev_mismatch(ev_mis_s[c]),
      .ev_extra   (ev_ext_s[c]),
      .ev_overflow(ev_ovf_s[c]),
      .exp_word   (exp_w_s[c]),
      .got_word   (got_w_s[c])
    );
  end

  err_hdr_t              hdr_r;
  err_hdr_t              hdr_nxt_s;
  logic [CH_W-1:0]       chan_nxt_s;
  logic [DATA_WIDTH-1:0] exp_nxt_s;
  logic [DATA_WIDTH-1:0] got_nxt_s;
  logic [NUM_CHAN-1:0]   ovf_nxt_s;
  logic [NUM_CHAN-1:0]   ext_nxt_s;
  logic [NUM_CHAN-1:0]   mis_nxt_s;
  logic [5:0]            n_ev_s;
  logic [15:0]           cnt_base_s;
  logic [16:0]           cnt_sum_s;
  logic [15:0]           cnt_nxt_s;
  logic                  any_ev_s;
  logic                  cap_open_s;
  logic [CH_W-1:0]       sel_chan_s;
  err_code_e             sel_code_s;
  logic [DATA_WIDTH-1:0] sel_exp_s;
  logic [DATA_WIDTH-1:0] sel_got_s;

  assign err_valid = hdr_r.valid;
  assign err_code  = hdr_r.code;

  // Sticky flags and saturating counter; clr clears first, same-cycle events still land.
  always_comb begin
    ovf_nxt_s  = (clr ? {NUM_CHAN{1'b0}} : overflow)  | ev_ovf_s;
    ext_nxt_s  = (clr ? {NUM_CHAN{1'b0}} : extradata) | ev_ext_s;
    mis_nxt_s  = (clr ? {NUM_CHAN{1'b0}} : mismatch)  | ev_mis_s;
    n_ev_s     = 6'd0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      n_ev_s = n_ev_s + 6'(ev_mis_s[c]) + 6'(ev_ext_s[c]) + 6'(ev_ovf_s[c]);
    end
    cnt_base_s = clr ? 16'h0000 : err_cnt;
    cnt_sum_s  = {1'b0, cnt_base_s} + {11'd0, n_ev_s};
    cnt_nxt_s  = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
  end

  // First-error capture: scan high to low so the lowest event channel wins.
  always_comb begin
    any_ev_s   = |(ev_mis_s | ev_ext_s | ev_ovf_s);
    cap_open_s = clr | ~hdr_r.valid;
    sel_chan_s = {CH_W{1'b0}};
    sel_code_s = ERR_NONE;
    sel_exp_s  = {DATA_WIDTH{1'b0}};
    sel_got_s  = {DATA_WIDTH{1'b0}};
    for (int c = NUM_CHAN - 1; c >= 0; c--) begin
      if (ev_mis_s[c] | ev_ext_s[c] | ev_ovf_s[c]) begin
        sel_chan_s = CH_W'(c);
        sel_code_s = err_code_f(ev_mis_s[c], ev_ext_s[c], ev_ovf_s[c]);
        sel_exp_s  = ev_mis_s[c] ? exp_w_s[c] : {DATA_WIDTH{1'b0}};
        sel_got_s  = got_w_s[c];
      end else begin
        sel_chan_s = sel_chan_s;
      end
    end
    if (cap_open_s && any_ev_s) begin
      hdr_nxt_s  = '{valid: 1'b1, code: sel_code_s};
      chan_nxt_s = sel_chan_s;
      exp_nxt_s  = sel_exp_s;
      got_nxt_s  = sel_got_s;
    end else if (clr) begin
      hdr_nxt_s  = '{valid: 1'b0, code: ERR_NONE};
      chan_nxt_s = {CH_W{1'b0}};
      exp_nxt_s  = {DATA_WIDTH{1'b0}};
      got_nxt_s  = {DATA_WIDTH{1'b0}};
    end else begin
      hdr_nxt_s  = hdr_r;
      chan_nxt_s = err_chan;
      exp_nxt_s  = err_exp;
      got_nxt_s  = err_got;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= {NUM_CHAN{1'b0}};
      extradata <= {NUM_CHAN{1'b0}};
      mismatch  <= {NUM_CHAN{1'b0}};
      error     <= 1'b0;
      err_cnt   <= 16'h0000;
      hdr_r     <= '{valid: 1'b0, code: ERR_NONE};
      err_chan  <= {CH_W{1'b0}};
      err_exp   <= {DATA_WIDTH{1'b0}};
      err_got   <= {DATA_WIDTH{1'b0}};
    end else begin
      overflow  <= ovf_nxt_s;
      extradata <= ext_nxt_s;
      mismatch  <= mis_nxt_s;
      error     <= |(ovf_nxt_s | ext_nxt_s | mis_nxt_s);
      err_cnt   <= cnt_nxt_s;
      hdr_r     <= hdr_nxt_s;
      err_chan  <= chan_nxt_s;
      err_exp   <= exp_nxt_s;
      err_got   <= got_nxt_s;
    end
  end

endmodule
